// File: rtl/mem_access_seq.sv
// Multicycle memory-access sequencer: decodes fetch/load/store requests, drives the
// memory port with lane-aligned data and byte enables, and formats the load result.
module mem_access_seq #(
  parameter  int XLEN    = 32,
  parameter  int TIMEOUT = 0,
  localparam int BE_W    = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic            fault,
  output logic [1:0]      fault_cause,
  output logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] rmask,
  output logic [BE_W-1:0] wmask,
  output logic [XLEN-1:0] mem_address,
  output logic            mem_read,
  output logic            mem_write,
  output logic [BE_W-1:0] mem_byte_enable,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_resp
);

  localparam int OFF_W = $clog2(BE_W);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) + 1 : 1;

  localparam logic [1:0] OP_FETCH = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [1:0] CAUSE_MISALIGN = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_FAULT} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [1:0]        r_op;
  logic [2:0]        r_f3;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic [1:0]        r_cause;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_in_illegal;
  logic              w_in_misal;
  logic [1:0]        w_in_szc;
  logic              w_tmo_hit;
  logic              w_acc;
  logic [OFF_W-1:0]  w_off;
  logic [1:0]        w_szc;
  logic              w_zext;
  logic [7:0]        w_szm8;
  logic [BE_W-1:0]   w_be;
  logic [XLEN-1:0]   w_shift;
  logic [XLEN-1:0]   w_keep;
  logic              w_sign;
  logic [XLEN-1:0]   w_load_fmt;

  // Request decode works on the live inputs; the same edge latches them.
  always_comb begin
    w_in_illegal = 1'b0;
    case (op)
      OP_LOAD:  w_in_illegal = (funct3 == 3'b111) ||
                               ((XLEN == 32) && (funct3 == 3'b011 || funct3 == 3'b110));
      OP_STORE: w_in_illegal = funct3[2] || ((XLEN == 32) && (funct3 == 3'b011));
      OP_ILL:   w_in_illegal = 1'b1;
      default:  w_in_illegal = 1'b0;
    endcase
    w_in_szc = (op == OP_FETCH) ? 2'd2 : funct3[1:0];
    w_in_misal = 1'b0;
    case (w_in_szc)
      2'd1:    w_in_misal = addr[0];
      2'd2:    w_in_misal = |addr[1:0];
      2'd3:    w_in_misal = |addr[2:0];
      default: w_in_misal = 1'b0;
    endcase
  end

  assign w_tmo_hit = (TIMEOUT > 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:
        if (start) w_state_next = (w_in_illegal || w_in_misal) ? ST_FAULT : ST_ACCESS;
      ST_ACCESS:
        // A response arriving on the limit cycle still completes the access.
        if (mem_resp)       w_state_next = ST_DONE;
        else if (w_tmo_hit) w_state_next = ST_FAULT;
      ST_DONE:  w_state_next = ST_IDLE;
      ST_FAULT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op    <= '0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_cause <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_op    <= op;
        r_f3    <= funct3;
        r_addr  <= addr;
        r_wdata <= wdata;
        r_cause <= w_in_illegal ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
        r_cnt   <= '0;
      end
      if (r_state == ST_ACCESS) begin
        if (mem_resp) begin
          r_rdata <= (r_op == OP_STORE) ? '0 : w_load_fmt;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_tmo_hit) r_cause <= CAUSE_TIMEOUT;
        end
      end
    end
  end

  // Lane geometry of the latched request; fetch is always an unsigned word.
  assign w_off  = r_addr[OFF_W-1:0];
  assign w_szc  = (r_op == OP_FETCH) ? 2'd2 : r_f3[1:0];
  assign w_zext = (r_op == OP_FETCH) || r_f3[2];

  always_comb begin
    w_szm8 = 8'hFF;
    w_keep = '1;
    w_sign = 1'b0;
    w_shift = mem_rdata >> {w_off, 3'b000};
    case (w_szc)
      2'd0: begin w_szm8 = 8'h01; w_keep = XLEN'(8'hFF);        w_sign = w_shift[7];  end
      2'd1: begin w_szm8 = 8'h03; w_keep = XLEN'(16'hFFFF);     w_sign = w_shift[15]; end
      2'd2: begin w_szm8 = 8'h0F; w_keep = XLEN'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
      default: begin w_szm8 = 8'hFF; w_keep = '1; w_sign = w_shift[XLEN-1]; end
    endcase
    w_be = w_szm8[BE_W-1:0] << w_off;
    w_load_fmt = (w_shift & w_keep) | ((w_sign && !w_zext) ? ~w_keep : '0);
  end

  assign w_acc = (r_state == ST_ACCESS);

  assign busy        = (r_state != ST_IDLE);
  assign done        = (r_state == ST_DONE);
  assign fault       = (r_state == ST_FAULT);
  assign fault_cause = fault ? r_cause : 2'd0;
  assign rdata       = r_rdata;
  assign rmask       = (done && r_op != OP_STORE) ? w_be : '0;
  assign wmask       = (done && r_op == OP_STORE) ? w_be : '0;

  assign mem_address     = w_acc ? {r_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign mem_read        = w_acc && (r_op != OP_STORE);
  assign mem_write       = w_acc && (r_op == OP_STORE);
  assign mem_byte_enable = w_acc ? w_be : '0;
  assign mem_wdata       = w_acc ? (r_wdata << {w_off, 3'b000}) : '0;

endmodule

// File: tb/tb_mem_access_seq.sv
// Directed bench for mem_access_seq: a 32-bit instance with TIMEOUT=4 and a
// 64-bit instance without timeout, checked against hand-computed values.
module tb_mem_access_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance signals
  logic        a_start, a_busy, a_done, a_fault, a_mem_read, a_mem_write, a_mem_resp;
  logic [1:0]  a_op, a_fault_cause;
  logic [2:0]  a_funct3;
  logic [31:0] a_addr, a_wdata, a_rdata, a_mem_address, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_rmask, a_wmask, a_mem_be;

  // 64-bit instance signals
  logic        b_start, b_busy, b_done, b_fault, b_mem_read, b_mem_write, b_mem_resp;
  logic [1:0]  b_op, b_fault_cause;
  logic [2:0]  b_funct3;
  logic [63:0] b_addr, b_wdata, b_rdata, b_mem_address, b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_rmask, b_wmask, b_mem_be;

  int n_checks = 0;
  int n_errors = 0;

  mem_access_seq #(.XLEN(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst), .start(a_start), .op(a_op), .funct3(a_funct3),
    .addr(a_addr), .wdata(a_wdata), .busy(a_busy), .done(a_done), .fault(a_fault),
    .fault_cause(a_fault_cause), .rdata(a_rdata), .rmask(a_rmask), .wmask(a_wmask),
    .mem_address(a_mem_address), .mem_read(a_mem_read), .mem_write(a_mem_write),
    .mem_byte_enable(a_mem_be), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
    .mem_resp(a_mem_resp)
  );

  mem_access_seq #(.XLEN(64), .TIMEOUT(0)) u_dut64 (
    .clk(clk), .rst(rst), .start(b_start), .op(b_op), .funct3(b_funct3),
    .addr(b_addr), .wdata(b_wdata), .busy(b_busy), .done(b_done), .fault(b_fault),
    .fault_cause(b_fault_cause), .rdata(b_rdata), .rmask(b_rmask), .wmask(b_wmask),
    .mem_address(b_mem_address), .mem_read(b_mem_read), .mem_write(b_mem_write),
    .mem_byte_enable(b_mem_be), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
    .mem_resp(b_mem_resp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Issue a request in cycle T and return at the sampling point of cycle T+1,
  // with the request inputs scrambled to show they were latched.
  task automatic go32(input logic [1:0] op, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] wd);
    a_start = 1'b1; a_op = op; a_funct3 = f3; a_addr = addr; a_wdata = wd;
    $display("txn32 op=%0d f3=%0d addr=0x%0h wdata=0x%0h", op, f3, addr, wd);
    tick();
    a_start = 1'b0; a_op = 2'b11; a_funct3 = 3'b111; a_addr = 32'hFFFF_FFFF; a_wdata = '0;
  endtask

  task automatic go64(input logic [1:0] op, input logic [2:0] f3,
                      input logic [63:0] addr, input logic [63:0] wd);
    b_start = 1'b1; b_op = op; b_funct3 = f3; b_addr = addr; b_wdata = wd;
    $display("txn64 op=%0d f3=%0d addr=0x%0h wdata=0x%0h", op, f3, addr, wd);
    tick();
    b_start = 1'b0; b_op = 2'b11; b_funct3 = 3'b111; b_addr = '1; b_wdata = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a_start = 0; a_op = 0; a_funct3 = 0; a_addr = 0; a_wdata = 0; a_mem_rdata = 0; a_mem_resp = 0;
    b_start = 0; b_op = 0; b_funct3 = 0; b_addr = 0; b_wdata = 0; b_mem_rdata = 0; b_mem_resp = 0;
    repeat (2) tick();

    // Reset state
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_fault", a_fault, 0);
    check("rst_rdata", a_rdata, 0);
    check("rst_mem_rd_wr", {a_mem_read, a_mem_write}, 0);
    check("rst_mem_be_addr", {a_mem_be, a_mem_address}, 0);
    check("rst_b_busy_rdata", {b_busy, b_rdata}, 0);
    rst = 1'b0;
    tick();

    // lb at 0x103, response after 3 cycles
    a_mem_rdata = 32'h80AA_BBCC;
    go32(2'b01, 3'b000, 32'h103, 0);
    check("lb_t1_read", a_mem_read, 1);
    check("lb_t1_addr", a_mem_address, 32'h100);
    check("lb_t1_be", a_mem_be, 4'b1000);
    check("lb_t1_busy", a_busy, 1);
    tick();
    check("lb_t2_read", a_mem_read, 1);
    tick();
    a_mem_resp = 1'b1;
    check("lb_t3_read", a_mem_read, 1);
    tick();
    a_mem_resp = 1'b0;
    check("lb_t4_done", a_done, 1);
    check("lb_t4_rdata", a_rdata, 32'hFFFF_FF80);
    check("lb_t4_rmask", a_rmask, 4'b1000);
    check("lb_t4_wmask", a_wmask, 0);
    check("lb_t4_read", a_mem_read, 0);
    check("lb_t4_fault", a_fault, 0);
    tick();
    check("lb_t5_idle", {a_done, a_busy, a_rmask}, 0);

    // lbu and lh against the same word
    go32(2'b01, 3'b100, 32'h103, 0);
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    check("lbu_rdata", a_rdata, 32'h0000_0080);
    tick();
    go32(2'b01, 3'b001, 32'h102, 0);
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    check("lh_rdata", a_rdata, 32'hFFFF_80AA);
    check("lh_rmask", a_rmask, 4'b1100);
    tick();

    // sh at 0x202, with a start while busy that must be dropped
    go32(2'b10, 3'b001, 32'h202, 32'h0000_1234);
    check("sh_t1_write", {a_mem_write, a_mem_read}, 2'b10);
    check("sh_t1_be", a_mem_be, 4'b1100);
    check("sh_t1_wdata", a_mem_wdata, 32'h1234_0000);
    check("sh_t1_addr", a_mem_address, 32'h200);
    tick();
    a_start = 1'b1; a_op = 2'b01; a_funct3 = 3'b010; a_addr = 32'h300;
    check("sh_t2_write", a_mem_write, 1);
    check("sh_t2_wdata", a_mem_wdata, 32'h1234_0000);
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    a_start = 1'b0;
    check("sh_t3_done", a_done, 1);
    check("sh_t3_wmask", a_wmask, 4'b1100);
    check("sh_t3_rmask", a_rmask, 0);
    check("sh_t3_write", a_mem_write, 0);
    tick();
    check("sh_noqueue", {a_busy, a_mem_read}, 0);

    // Decode faults
    go32(2'b01, 3'b010, 32'h101, 0);
    check("lw_mis_fault", a_fault, 1);
    check("lw_mis_cause", a_fault_cause, 0);
    check("lw_mis_read", a_mem_read, 0);
    check("lw_mis_done", a_done, 0);
    tick();
    check("lw_mis_after", {a_fault, a_busy}, 0);
    go32(2'b11, 3'b000, 32'h100, 0);
    check("op11_fault", {a_fault, a_fault_cause}, {1'b1, 2'd2});
    tick();
    go32(2'b01, 3'b011, 32'h101, 0);
    check("ld32_fault", {a_fault, a_fault_cause, a_mem_read}, {1'b1, 2'd2, 1'b0});
    tick();
    go32(2'b10, 3'b100, 32'h100, 0);
    check("st100_fault", {a_fault, a_fault_cause, a_mem_write}, {1'b1, 2'd2, 1'b0});
    tick();

    // Timeout with no response
    go32(2'b01, 3'b010, 32'h100, 0);
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) tick();
      check($sformatf("tmo_read_c%0d", i), a_mem_read, 1);
    end
    tick();
    check("tmo_fault", {a_fault, a_fault_cause, a_done, a_mem_read}, {1'b1, 2'd1, 1'b0, 1'b0});
    tick();
    check("tmo_idle", {a_busy, a_fault}, 0);

    // Response on the limit cycle wins
    a_mem_rdata = 32'h1234_5678;
    go32(2'b01, 3'b010, 32'h100, 0);
    repeat (3) tick();
    a_mem_resp = 1'b1;
    check("tmo_edge_read", a_mem_read, 1);
    tick();
    a_mem_resp = 1'b0;
    check("tmo_edge_done", {a_done, a_fault}, 2'b10);
    check("tmo_edge_rdata", a_rdata, 32'h1234_5678);
    tick();

    // Reset in the second ACCESS cycle, then a stray response
    go32(2'b01, 3'b010, 32'h100, 0);
    tick();
    check("rstacc_read", a_mem_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    a_mem_resp = 1'b1;
    check("rstacc_idle", {a_busy, a_mem_read, a_done, a_fault}, 0);
    check("rstacc_rdata", a_rdata, 0);
    tick();
    a_mem_resp = 1'b0;
    check("rstacc_stray", {a_busy, a_done, a_fault}, 0);
    a_mem_rdata = 32'hDEAD_BEEF;
    go32(2'b00, 3'b111, 32'h200, 0);
    check("fetch_be", {a_mem_read, a_mem_be}, {1'b1, 4'hF});
    a_mem_resp = 1'b1;
    tick();
    a_mem_resp = 1'b0;
    check("fetch_done", {a_done, a_rmask}, {1'b1, 4'hF});
    check("fetch_rdata", a_rdata, 32'hDEAD_BEEF);
    tick();

    // 64-bit: ld with a long wait (no timeout configured)
    b_mem_rdata = 64'h0123_4567_89AB_CDEF;
    go64(2'b01, 3'b011, 64'h1008, 0);
    check("ld_be", b_mem_be, 8'hFF);
    check("ld_addr", b_mem_address, 64'h1008);
    repeat (6) tick();
    check("ld_wait_read", {b_mem_read, b_fault}, 2'b10);
    b_mem_resp = 1'b1;
    tick();
    b_mem_resp = 1'b0;
    check("ld_done", {b_done, b_rmask}, {1'b1, 8'hFF});
    check("ld_rdata", b_rdata, 64'h0123_4567_89AB_CDEF);
    tick();

    // lwu / lw at 0x1004
    b_mem_rdata = 64'h8000_0001_1111_1111;
    go64(2'b01, 3'b110, 64'h1004, 0);
    check("lwu_be", b_mem_be, 8'hF0);
    check("lwu_addr", b_mem_address, 64'h1000);
    b_mem_resp = 1'b1;
    tick();
    b_mem_resp = 1'b0;
    check("lwu_rdata", b_rdata, 64'h0000_0000_8000_0001);
    tick();
    go64(2'b01, 3'b010, 64'h1004, 0);
    b_mem_resp = 1'b1;
    tick();
    b_mem_resp = 1'b0;
    check("lw64_rdata", b_rdata, 64'hFFFF_FFFF_8000_0001);
    tick();

    // sh at 0x1006 on the wide bus
    go64(2'b10, 3'b001, 64'h1006, 64'h0000_ABCD);
    check("sh64_be", b_mem_be, 8'hC0);
    check("sh64_wdata", b_mem_wdata, 64'hABCD_0000_0000_0000);
    b_mem_resp = 1'b1;
    tick();
    b_mem_resp = 1'b0;
    check("sh64_wmask", {b_done, b_wmask}, {1'b1, 8'hC0});
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
